// File: rtl/usb_fs_arb_pkg.sv
// usb_fs_arb_pkg
//   Shared definitions for the full-speed endpoint arbiters: the arbiter
//   state encoding, the grant index width and the hold counter width.
package usb_fs_arb_pkg;

   // Width of grant_idx / rr_ptr, sized for up to 16 endpoints.
   localparam int GRANT_IDX_W = 4;

   // Width of the idle-hold counter, matching the MAX_HOLD range.
   localparam int HOLD_CNT_W = 16;

   typedef enum logic [0:0] {
      ST_IDLE    = 1'b0,
      ST_GRANTED = 1'b1
   } arb_state_e;

endpackage

// File: rtl/usb_rr_pick.sv
// usb_rr_pick
//   Combinational rotate-priority picker. It returns the first set request
//   bit at or after ptr, scanning upward and wrapping from N-1 to 0.
//   Ports:
//     req  in  N            request vector
//     ptr  in  GRANT_IDX_W  starting index of the scan (must be < N)
//     pick out N            one-hot pick (all zero when nothing requests)
//     idx  out GRANT_IDX_W  index of the pick (0 when nothing requests)
//     any  out 1            at least one request bit is set
module usb_rr_pick
   import usb_fs_arb_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]           req,
   input  logic [GRANT_IDX_W-1:0] ptr,
   output logic [N-1:0]           pick,
   output logic [GRANT_IDX_W-1:0] idx,
   output logic                   any
);

   // Walk the candidates in rotated order; the first requester wins.
   always_comb begin
      int  cand;
      logic found;
      pick  = '0;
      idx   = '0;
      any   = 1'b0;
      found = 1'b0;
      cand  = 0;
      for (int i = 0; i < N; i++) begin
         cand = int'(ptr) + i;
         if (cand >= N) begin
            cand = cand - N;
         end else begin
            cand = cand;
         end
         if (!found && req[cand]) begin
            found      = 1'b1;
            pick[cand] = 1'b1;
            idx        = GRANT_IDX_W'(cand);
            any        = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/usb_fs_in_rr_arb.sv
// usb_fs_in_rr_arb
//   Round-robin, grant-locking arbiter sharing the IN protocol-engine
//   datapath between NUM_IN_EPS IN endpoints. A grant is held while the
//   granted endpoint requests or the protocol engine is busy; an optional
//   idle-hold timeout forces a release when another endpoint is waiting.
//   Ports:
//     clk             in  1             protocol-engine clock
//     reset           in  1             asynchronous, active-high reset
//     in_ep_req       in  NUM_IN_EPS    per-endpoint request level
//     in_ep_data      in  NUM_IN_EPS*8  endpoint i byte at [8i+7:8i]
//     pe_busy         in  1             IN protocol engine mid-transaction
//     in_ep_grant     out NUM_IN_EPS    registered one-hot grant
//     arb_in_ep_data  out 8             byte of the granted endpoint, else 0
//     grant_valid     out 1             a grant is active
//     grant_idx       out 4             index of the granted endpoint, else 0
//     hold_timeout    out 1             pulse when a grant is force-released
module usb_fs_in_rr_arb
   import usb_fs_arb_pkg::*;
#(
   parameter int NUM_IN_EPS = 4,
   parameter int MAX_HOLD   = 0
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_IN_EPS-1:0]     in_ep_req,
   input  logic [NUM_IN_EPS*8-1:0]   in_ep_data,
   input  logic                      pe_busy,
   output logic [NUM_IN_EPS-1:0]     in_ep_grant,
   output logic [7:0]                arb_in_ep_data,
   output logic                      grant_valid,
   output logic [GRANT_IDX_W-1:0]    grant_idx,
   output logic                      hold_timeout
);

   localparam logic [GRANT_IDX_W-1:0] LAST_IDX    = GRANT_IDX_W'(NUM_IN_EPS - 1);
   localparam logic [HOLD_CNT_W-1:0]  HOLD_LIMIT  = HOLD_CNT_W'(MAX_HOLD);
   localparam logic [HOLD_CNT_W-1:0]  HOLD_SAT    = {HOLD_CNT_W{1'b1}};
   localparam logic                   TIMEOUT_ON  = (MAX_HOLD != 0);

   arb_state_e                 state_r,        state_nxt_s;
   logic [NUM_IN_EPS-1:0]      grant_r,        grant_nxt_s;
   logic [GRANT_IDX_W-1:0]     grant_idx_r,    grant_idx_nxt_s;
   logic                       grant_valid_r,  grant_valid_nxt_s;
   logic [GRANT_IDX_W-1:0]     rr_ptr_r,       rr_ptr_nxt_s;
   logic [HOLD_CNT_W-1:0]      hold_cnt_r,     hold_cnt_nxt_s;
   logic                       hold_timeout_r, hold_timeout_nxt_s;

   logic [NUM_IN_EPS-1:0]      pick_s;
   logic [GRANT_IDX_W-1:0]     pick_idx_s;
   logic                       pick_any_s;
   logic                       held_req_s;
   logic                       others_req_s;
   logic                       timeout_hit_s;
   logic [GRANT_IDX_W-1:0]     release_ptr_s;

   usb_rr_pick #(
      .N (NUM_IN_EPS)
   ) u_pick (
      .req  (in_ep_req),
      .ptr  (rr_ptr_r),
      .pick (pick_s),
      .idx  (pick_idx_s),
      .any  (pick_any_s)
   );

   // Only the granted endpoint's request keeps the lock; the others only
   // matter to the timeout, which needs someone else to be waiting.
   assign held_req_s    = |(in_ep_req & grant_r);
   assign others_req_s  = |(in_ep_req & ~grant_r);
   assign timeout_hit_s = TIMEOUT_ON && !pe_busy && others_req_s &&
                          (hold_cnt_r == HOLD_LIMIT);
   assign release_ptr_s = (grant_idx_r == LAST_IDX) ? '0 : grant_idx_r + 4'd1;

   // Next-state and next-register logic of the arbitration FSM.
   always_comb begin
      state_nxt_s        = state_r;
      grant_nxt_s        = grant_r;
      grant_idx_nxt_s    = grant_idx_r;
      grant_valid_nxt_s  = grant_valid_r;
      rr_ptr_nxt_s       = rr_ptr_r;
      hold_cnt_nxt_s     = hold_cnt_r;
      hold_timeout_nxt_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pick_any_s) begin
               state_nxt_s       = ST_GRANTED;
               grant_nxt_s       = pick_s;
               grant_idx_nxt_s   = pick_idx_s;
               grant_valid_nxt_s = 1'b1;
               hold_cnt_nxt_s    = '0;
            end else begin
               grant_nxt_s       = '0;
               grant_idx_nxt_s   = '0;
               grant_valid_nxt_s = 1'b0;
            end
         end
         ST_GRANTED: begin
            if ((!held_req_s && !pe_busy) || timeout_hit_s) begin
               // Normal and forced releases both advance the pointer past
               // the outgoing grantee; only the forced one pulses.
               state_nxt_s        = ST_IDLE;
               grant_nxt_s        = '0;
               grant_idx_nxt_s    = '0;
               grant_valid_nxt_s  = 1'b0;
               rr_ptr_nxt_s       = release_ptr_s;
               hold_cnt_nxt_s     = '0;
               hold_timeout_nxt_s = held_req_s || pe_busy;
            end else if (pe_busy) begin
               hold_cnt_nxt_s = '0;
            end else if (hold_cnt_r != HOLD_SAT) begin
               hold_cnt_nxt_s = hold_cnt_r + 16'd1;
            end else begin
               hold_cnt_nxt_s = hold_cnt_r;
            end
         end
         default: begin
            state_nxt_s       = ST_IDLE;
            grant_nxt_s       = '0;
            grant_idx_nxt_s   = '0;
            grant_valid_nxt_s = 1'b0;
            rr_ptr_nxt_s      = '0;
            hold_cnt_nxt_s    = '0;
         end
      endcase
   end

   // State and registered outputs of the arbiter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         grant_r        <= '0;
         grant_idx_r    <= '0;
         grant_valid_r  <= 1'b0;
         rr_ptr_r       <= '0;
         hold_cnt_r     <= '0;
         hold_timeout_r <= 1'b0;
      end else begin
         state_r        <= state_nxt_s;
         grant_r        <= grant_nxt_s;
         grant_idx_r    <= grant_idx_nxt_s;
         grant_valid_r  <= grant_valid_nxt_s;
         rr_ptr_r       <= rr_ptr_nxt_s;
         hold_cnt_r     <= hold_cnt_nxt_s;
         hold_timeout_r <= hold_timeout_nxt_s;
      end
   end

   // Data mux driven by the registered one-hot grant; all zero when idle.
   always_comb begin
      arb_in_ep_data = 8'h00;
      for (int i = 0; i < NUM_IN_EPS; i++) begin
         arb_in_ep_data = arb_in_ep_data | ({8{grant_r[i]}} & in_ep_data[8*i +: 8]);
      end
   end

   assign in_ep_grant  = grant_r;
   assign grant_valid  = grant_valid_r;
   assign grant_idx    = grant_idx_r;
   assign hold_timeout = hold_timeout_r;

endmodule

// File: tb/tb_usb_fs_in_rr_arb.sv
// tb_usb_fs_in_rr_arb
//   Directed bench for usb_fs_in_rr_arb with four endpoints and MAX_HOLD=8.
//   Inputs change 1 time unit after the rising edge; outputs are checked
//   at the same point, well away from the next edge.
module tb_usb_fs_in_rr_arb;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  in_ep_req;
   logic [31:0] in_ep_data;
   logic        pe_busy;
   logic [3:0]  in_ep_grant;
   logic [7:0]  arb_in_ep_data;
   logic        grant_valid;
   logic [3:0]  grant_idx;
   logic        hold_timeout;

   int tests_run    = 0;
   int tests_failed = 0;

   usb_fs_in_rr_arb #(
      .NUM_IN_EPS (4),
      .MAX_HOLD   (8)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .in_ep_req      (in_ep_req),
      .in_ep_data     (in_ep_data),
      .pe_busy        (pe_busy),
      .in_ep_grant    (in_ep_grant),
      .arb_in_ep_data (arb_in_ep_data),
      .grant_valid    (grant_valid),
      .grant_idx      (grant_idx),
      .hold_timeout   (hold_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b want 0000", in_ep_grant); end
      tests_run++;
      if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b want 0", grant_valid); end
      tests_run++;
      if (grant_idx !== 4'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d want 0", grant_idx); end
      tests_run++;
      if (hold_timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b want 0", hold_timeout); end
      tests_run++;
      if (arb_in_ep_data !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h want 00", arb_in_ep_data); end
      reset = 1'b0;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL idle_no_req: got %b want 0000", in_ep_grant); end
   endtask

   task automatic test_single();
      in_ep_req = 4'b0100;
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL single_pre: got %b want 0000", in_ep_grant); end
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0100) begin tests_failed++; $display("FAIL single_grant: got %b want 0100", in_ep_grant); end
      tests_run++;
      if (grant_idx !== 4'd2) begin tests_failed++; $display("FAIL single_idx: got %0d want 2", grant_idx); end
      tests_run++;
      if (grant_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b want 1", grant_valid); end
      tests_run++;
      if (arb_in_ep_data !== 8'hB3) begin tests_failed++; $display("FAIL single_data: got %h want b3", arb_in_ep_data); end
      in_ep_req = 4'b0000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL single_release: got %b want 0000", in_ep_grant); end
      tests_run++;
      if (arb_in_ep_data !== 8'h00) begin tests_failed++; $display("FAIL single_data_idle: got %h want 00", arb_in_ep_data); end
      tests_run++;
      if (grant_idx !== 4'd0) begin tests_failed++; $display("FAIL single_idx_idle: got %0d want 0", grant_idx); end
   endtask

   // rr_ptr is 3 after endpoint 2 was released above.
   task automatic test_wrap();
      in_ep_req = 4'b0011;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0001) begin tests_failed++; $display("FAIL wrap_grant: got %b want 0001", in_ep_grant); end
      tests_run++;
      if (grant_idx !== 4'd0) begin tests_failed++; $display("FAIL wrap_idx: got %0d want 0", grant_idx); end
      in_ep_req = 4'b0000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL wrap_release: got %b want 0000", in_ep_grant); end
   endtask

   task automatic test_rotation();
      logic [3:0] exp_g;
      int         exp_i;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_ep_req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_i = k % 4;
         exp_g = 4'b0001 << exp_i;
         tick();
         tests_run++;
         if (in_ep_grant !== exp_g) begin tests_failed++; $display("FAIL rot_grant[%0d]: got %b want %b", k, in_ep_grant, exp_g); end
         tests_run++;
         if (grant_idx !== 4'(exp_i)) begin tests_failed++; $display("FAIL rot_idx[%0d]: got %0d want %0d", k, grant_idx, exp_i); end
         tests_run++;
         if (arb_in_ep_data !== in_ep_data[8*exp_i +: 8]) begin tests_failed++; $display("FAIL rot_data[%0d]: got %h want %h", k, arb_in_ep_data, in_ep_data[8*exp_i +: 8]); end
         tick();
         tick();
         tests_run++;
         if (in_ep_grant !== exp_g) begin tests_failed++; $display("FAIL rot_hold[%0d]: got %b want %b", k, in_ep_grant, exp_g); end
         in_ep_req[exp_i] = 1'b0;
         tick();
         tests_run++;
         if (in_ep_grant !== 4'b0000 || grant_valid !== 1'b0) begin tests_failed++; $display("FAIL rot_gap[%0d]: got %b/%b want 0000/0", k, in_ep_grant, grant_valid); end
         in_ep_req[exp_i] = 1'b1;
      end
   endtask

   // rr_ptr is 1 after the rotation ended on endpoint 0.
   task automatic test_lock_busy();
      in_ep_req = 4'b0011;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0010) begin tests_failed++; $display("FAIL lock_grant: got %b want 0010", in_ep_grant); end
      pe_busy   = 1'b1;
      in_ep_req = 4'b0001;
      for (int k = 0; k < 4; k++) begin
         tick();
         tests_run++;
         if (in_ep_grant !== 4'b0010) begin tests_failed++; $display("FAIL lock_hold[%0d]: got %b want 0010", k, in_ep_grant); end
      end
      pe_busy = 1'b0;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL lock_release: got %b want 0000", in_ep_grant); end
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0001) begin tests_failed++; $display("FAIL lock_next: got %b want 0001", in_ep_grant); end
      in_ep_req = 4'b0000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL lock_end: got %b want 0000", in_ep_grant); end
   endtask

   // hold_cnt reads 8 after the 8th idle edge; the forced release lands on
   // the following edge together with the timeout pulse.
   task automatic test_timeout();
      in_ep_req = 4'b1000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b1000) begin tests_failed++; $display("FAIL tmo_grant: got %b want 1000", in_ep_grant); end
      in_ep_req = 4'b1001;
      for (int k = 1; k <= 8; k++) begin
         tick();
         tests_run++;
         if (in_ep_grant !== 4'b1000 || hold_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_hold[%0d]: got %b/%b want 1000/0", k, in_ep_grant, hold_timeout); end
      end
      tick();
      tests_run++;
      if (hold_timeout !== 1'b1) begin tests_failed++; $display("FAIL tmo_pulse: got %b want 1", hold_timeout); end
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL tmo_drop: got %b want 0000", in_ep_grant); end
      tick();
      tests_run++;
      if (hold_timeout !== 1'b0) begin tests_failed++; $display("FAIL tmo_pulse_end: got %b want 0", hold_timeout); end
      tests_run++;
      if (in_ep_grant !== 4'b0001) begin tests_failed++; $display("FAIL tmo_next: got %b want 0001", in_ep_grant); end
      in_ep_req = 4'b0000;
      tick();
   endtask

   task automatic test_no_timeout();
      in_ep_req = 4'b1000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b1000) begin tests_failed++; $display("FAIL notmo_grant: got %b want 1000", in_ep_grant); end
      for (int k = 0; k < 20; k++) begin
         tick();
         tests_run++;
         if (in_ep_grant !== 4'b1000 || hold_timeout !== 1'b0) begin tests_failed++; $display("FAIL notmo_hold[%0d]: got %b/%b want 1000/0", k, in_ep_grant, hold_timeout); end
      end
      in_ep_req = 4'b0000;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL notmo_release: got %b want 0000", in_ep_grant); end
   endtask

   task automatic test_async_reset();
      in_ep_req = 4'b0100;
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0100) begin tests_failed++; $display("FAIL areset_pre: got %b want 0100", in_ep_grant); end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if (in_ep_grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 4'd0) begin tests_failed++; $display("FAIL areset_grant: got %b/%b/%0d want 0000/0/0", in_ep_grant, grant_valid, grant_idx); end
      tests_run++;
      if (arb_in_ep_data !== 8'h00 || hold_timeout !== 1'b0) begin tests_failed++; $display("FAIL areset_misc: got %h/%b want 00/0", arb_in_ep_data, hold_timeout); end
      in_ep_req = 4'b1010;
      tick();
      reset = 1'b0;
      tests_run++;
      if (in_ep_grant !== 4'b0000) begin tests_failed++; $display("FAIL areset_held: got %b want 0000", in_ep_grant); end
      tick();
      tests_run++;
      if (in_ep_grant !== 4'b0010 || grant_idx !== 4'd1) begin tests_failed++; $display("FAIL areset_first: got %b/%0d want 0010/1", in_ep_grant, grant_idx); end
      tests_run++;
      if (arb_in_ep_data !== 8'hC2) begin tests_failed++; $display("FAIL areset_data: got %h want c2", arb_in_ep_data); end
      in_ep_req = 4'b0000;
      tick();
   endtask

   initial begin
      reset      = 1'b1;
      in_ep_req  = 4'b0000;
      pe_busy    = 1'b0;
      in_ep_data = 32'hA4B3_C2D1;
      test_reset();
      test_single();
      test_wrap();
      test_rotation();
      test_lock_busy();
      test_timeout();
      test_no_timeout();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/usb_fs_in_rr_arb.md
# usb_fs_in_rr_arb

Round-robin, grant-locking arbiter that shares the single IN protocol-engine datapath (tx data byte, data_put/done strobes) between `NUM_IN_EPS` IN endpoints. It replaces fixed-priority selection with fair rotation and holds each grant stable for the whole of a protocol-engine transaction. An optional hold timeout stops one endpoint from starving the others. It sits between the endpoint request/grant wires and the IN protocol engine, inside the full-speed protocol-engine top level.

## Interface
Parameters:
- `NUM_IN_EPS`, 4: number of IN endpoint requesters, 1..16.
- `MAX_HOLD`, 0: maximum idle-hold cycles before forced release; 0 disables the timeout; 16-bit range.

Ports:
- `clk`  in  1  protocol-engine clock (48 MHz).
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `in_ep_req`  in  NUM_IN_EPS  per-endpoint request, level.
- `in_ep_data`  in  NUM_IN_EPS*8  per-endpoint data bytes; endpoint i occupies bits [8i+7:8i].
- `pe_busy`  in  1  high while the IN protocol engine is mid-transaction (token through handshake).
- `in_ep_grant`  out  NUM_IN_EPS  one-hot grant, registered.
- `arb_in_ep_data`  out  8  data byte of the granted endpoint; 0 when there is no grant.
- `grant_valid`  out  1  OR of `in_ep_grant`.
- `grant_idx`  out  4  index of the granted endpoint; 0 when there is no grant.
- `hold_timeout`  out  1  one-cycle pulse when a grant is force-released.

## Operation
- State machine with two states, IDLE and GRANTED.
- IDLE:
  - If any `in_ep_req` bit is set, select the first requester at or after `rr_ptr`, scanning upward with wrap from NUM_IN_EPS-1 to 0.
  - Register the one-hot grant and go to GRANTED.
  - If no request is present, stay in IDLE.
- GRANTED, holding endpoint g:
  - The grant holds while `in_ep_req[g]` is high or `pe_busy` is high.
  - A request drop during `pe_busy` does not release the grant.
  - Release: `in_ep_req[g]`=0 and `pe_busy`=0. Go to IDLE and set `rr_ptr` = (g+1) mod NUM_IN_EPS.
- Timeout, active only when MAX_HOLD≠0:
  - `hold_cnt` increments each GRANTED cycle with `pe_busy`=0. It clears on entering GRANTED and in any cycle with `pe_busy`=1. It saturates.
  - When `hold_cnt` == MAX_HOLD and another endpoint is requesting:
    - release to IDLE;
    - pulse `hold_timeout`;
    - advance `rr_ptr` as for a normal release.
  - With no other requester pending, there is no forced release.
- `arb_in_ep_data` is a combinational mux from the registered grant. No other outputs are combinational.
- Request bits of ungranted endpoints never affect the current grant.

## Timing
- Reset values:
  - `in_ep_grant`=0, `grant_valid`=0, `grant_idx`=0;
  - `hold_timeout`=0, `arb_in_ep_data`=0;
  - `rr_ptr`=0, `hold_cnt`=0, state IDLE.
- Request to grant: 1 cycle (request sampled in IDLE at edge N, grant visible after edge N+1).
- Release to next grant: release is sampled at edge N and the grant drops after edge N+1. The IDLE cycle arbitrates and the new grant appears after edge N+2. At least one cycle with all grants zero always separates two grants.
- `hold_timeout` is high in the same cycle the grant drops.
- Simultaneous requests are resolved by `rr_ptr` only.
- Reset asserted mid-grant: grant deasserts asynchronously. The first post-reset grant goes to the lowest-index requester.
- NUM_IN_EPS=1: `rr_ptr` is always 0 and the timeout never fires (no other requester exists).

## Structure
- Shared package/header `usb_fs_arb_pkg`: state encodings (IDLE, GRANTED) and the `grant_idx` width constant (4).
- Sub-module `usb_rr_pick`: combinational rotate-priority picker. Inputs are the req vector and `rr_ptr`; outputs are the one-hot pick, the pick index and an any flag. It can be reused later for OUT endpoint arbitration.
- Top of the block: FSM, `rr_ptr`, `hold_cnt`, grant register and data mux.

## Test plan
- Single request: reset, then `in_ep_req`=4'b0100. Expect `in_ep_grant`=4'b0100 and `grant_idx`=2 one cycle later, and `arb_in_ep_data` equal to bits [23:16].
- Rotation: hold `in_ep_req`=4'b1111, with each grantee dropping its request 3 cycles after grant. Expect grant order 0,1,2,3,0 with one all-zero cycle between consecutive grants.
- Lock during busy: grant endpoint 1, raise `pe_busy`, drop `in_ep_req[1]`, keep `in_ep_req[0]` high. Expect the grant to stay 4'b0010 until `pe_busy` falls, then 0, then 4'b0001.
- Timeout: with MAX_HOLD=8, endpoint 3 holds its request with `pe_busy`=0 while endpoint 0 is requesting. Expect `hold_timeout` pulsed and the grant dropped 8 cycles after grant, then 4'b0001. Repeat without endpoint 0 requesting: expect no timeout.
- Wrap: `rr_ptr`=3 after a release of endpoint 2, with requests 4'b0011. Expect the grant to go to endpoint 0, not endpoint 1.
- Async reset mid-grant: assert `reset` between clock edges while granted. Expect all outputs zero immediately. After release of reset with requests 4'b1010, expect a grant to endpoint 1.
